nxn_board_game: RTL and testbench



---
 rtl/nxn_board_game.sv | 221 ++++++++++++++++++++++
 tb/tb_nxn_board_game.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nxn_board_game.sv
// nxn_board_game: N x N board game with a K-in-a-row win condition.
//
// After each accepted move, only the four lines through the placed cell are
// scanned, one direction per cycle (horizontal, vertical, diagonal,
// anti-diagonal). The result is known four cycles after the accept.
//
// Parameters: N (board side, 3..8), K (win length, 3..N), PW (derived index width)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   play_x / play_o     move request strobes (level-sampled)
//   x_pos / o_pos       target cell index, row*N+col
//   board               flattened board, cell i at [2i+1:2i] (00 empty, 01 X, 10 O)
//   turn                0 = X to move, 1 = O to move
//   busy                win check in progress
//   illegal             one-cycle pulse on a rejected move
//   who                 00 none, 01 X, 10 O, 11 draw
//   game_over           high once who != 00
//   move_count          (only with MOVE_COUNT_EN) number of accepted moves
//
// Optional feature macro: MOVE_COUNT_EN adds move_count and uses it for the
// board-full test instead of a reduction over all cells.
module nxn_board_game #(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int PW = $clog2(N*N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play_x,
  input  logic             play_o,
  input  logic [PW-1:0]    x_pos,
  input  logic [PW-1:0]    o_pos,
  output logic [2*N*N-1:0] board,
  output logic             turn,
  output logic             busy,
  output logic             illegal,
  output logic [1:0]       who,
  output logic             game_over
`ifdef MOVE_COUNT_EN
  ,
  output logic [PW:0]      move_count
`endif
);

  localparam int CELLS = N*N;
  localparam int CW    = $clog2(K) + 1;
  localparam int RW    = $clog2(N);

  typedef enum logic [2:0] {S_WAIT, S_CHK0, S_CHK1, S_CHK2, S_CHK3, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [2*N*N-1:0]   board_q, board_d;
  logic               turn_q, turn_d;
  logic               busy_q, busy_d;
  logic               illegal_q, illegal_d;
  logic [1:0]         who_q, who_d;
  logic [RW-1:0]      row_q, row_d;
  logic [RW-1:0]      col_q, col_d;
  logic               hit_q, hit_d;
`ifdef MOVE_COUNT_EN
  logic [PW:0]        mc_q, mc_d;
`endif

  logic [1:0]         mark;
  logic [CW-1:0]      cnt_p, cnt_n;
  logic               hit_now;
  logic               full;

  // Mark of the player who just moved; turn only toggles at the end of the check.
  assign mark = turn_q ? 2'b10 : 2'b01;

  // Count contiguous mover marks from the origin in the current direction.
  always_comb begin : scan
    int  dr, dc, r, c;
    logic run_p, run_n;
    dr = 0;
    dc = 1;
    case (state_q)
      S_CHK1:  begin dr = 1; dc = 0;  end
      S_CHK2:  begin dr = 1; dc = 1;  end
      S_CHK3:  begin dr = 1; dc = -1; end
      default: begin dr = 0; dc = 1;  end
    endcase
    cnt_p = '0;
    cnt_n = '0;
    run_p = 1'b1;
    run_n = 1'b1;
    for (int s = 1; s < K; s++) begin
      r = int'(row_q) + s*dr;
      c = int'(col_q) + s*dc;
      if (run_p && r >= 0 && r < N && c >= 0 && c < N) begin
        if (board_q[2*(r*N+c) +: 2] == mark) cnt_p = cnt_p + CW'(1);
        else                                 run_p = 1'b0;
      end else begin
        run_p = 1'b0;
      end
      r = int'(row_q) - s*dr;
      c = int'(col_q) - s*dc;
      if (run_n && r >= 0 && r < N && c >= 0 && c < N) begin
        if (board_q[2*(r*N+c) +: 2] == mark) cnt_n = cnt_n + CW'(1);
        else                                 run_n = 1'b0;
      end else begin
        run_n = 1'b0;
      end
    end
    hit_now = (int'(cnt_p) + int'(cnt_n) + 1) >= K;
  end

`ifdef MOVE_COUNT_EN
  assign full = (int'(mc_q) == CELLS);
`else
  always_comb begin
    full = 1'b1;
    for (int i = 0; i < CELLS; i++)
      if (board_q[2*i +: 2] == 2'b00) full = 1'b0;
  end
`endif

  always_comb begin
    logic req, occupied;
    int   pos_i;
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    busy_d    = busy_q;
    illegal_d = 1'b0;
    who_d     = who_q;
    row_d     = row_q;
    col_d     = col_q;
    hit_d     = hit_q;
`ifdef MOVE_COUNT_EN
    mc_d      = mc_q;
`endif
    req       = 1'b0;
    occupied  = 1'b0;
    pos_i     = 0;
    case (state_q)
      S_WAIT: begin
        // Only the current player's strobe is looked at.
        req   = turn_q ? play_o : play_x;
        pos_i = int'(turn_q ? o_pos : x_pos);
        if (pos_i < CELLS) occupied = (board_q[2*pos_i +: 2] != 2'b00);
        else               occupied = 1'b1;
        if (req) begin
          if (occupied) begin
            illegal_d = 1'b1;
          end else begin
            board_d[2*pos_i +: 2] = mark;
            row_d   = RW'(pos_i / N);
            col_d   = RW'(pos_i % N);
            hit_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_CHK0;
`ifdef MOVE_COUNT_EN
            mc_d    = mc_q + 1'b1;
`endif
          end
        end
      end
      S_CHK0: begin hit_d = hit_q | hit_now; state_d = S_CHK1; end
      S_CHK1: begin hit_d = hit_q | hit_now; state_d = S_CHK2; end
      S_CHK2: begin hit_d = hit_q | hit_now; state_d = S_CHK3; end
      S_CHK3: begin
        busy_d = 1'b0;
        // A win on the last free cell beats the draw.
        if (hit_q | hit_now) begin
          who_d   = mark;
          state_d = S_OVER;
        end else if (full) begin
          who_d   = 2'b11;
          state_d = S_OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_OVER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT;
      board_q   <= '0;
      turn_q    <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
      who_q     <= 2'b00;
      row_q     <= '0;
      col_q     <= '0;
      hit_q     <= 1'b0;
`ifdef MOVE_COUNT_EN
      mc_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
      who_q     <= who_d;
      row_q     <= row_d;
      col_q     <= col_d;
      hit_q     <= hit_d;
`ifdef MOVE_COUNT_EN
      mc_q      <= mc_d;
`endif
    end
  end

  assign board     = board_q;
  assign turn      = turn_q;
  assign busy      = busy_q;
  assign illegal   = illegal_q;
  assign who       = who_q;
  assign game_over = (who_q != 2'b00);
`ifdef MOVE_COUNT_EN
  assign move_count = mc_q;
`endif

endmodule

// File: tb/tb_nxn_board_game.sv
// Testbench for nxn_board_game: one 3x3/K=3 instance and one 5x5/K=4 instance,
// directed game sequences plus random play compared against a whole-board
// reference model.
module tb_nxn_board_game;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  px = '0, po = '0;
  logic [3:0]  xp0 = '0, op0 = '0;
  logic [4:0]  xp1 = '0, op1 = '0;
  wire  [17:0] board3;
  wire  [49:0] board5;
  wire  [1:0]  turn_w, busy_w, ill_w, go_w;
  wire  [1:0]  who0, who1;
`ifdef MOVE_COUNT_EN
  wire  [4:0]  mc0;
  wire  [5:0]  mc1;
`endif

  nxn_board_game #(.N(3), .K(3)) u_g3 (
    .clk(clk), .rst(rst), .play_x(px[0]), .play_o(po[0]), .x_pos(xp0), .o_pos(op0),
    .board(board3), .turn(turn_w[0]), .busy(busy_w[0]), .illegal(ill_w[0]),
    .who(who0), .game_over(go_w[0])
`ifdef MOVE_COUNT_EN
    , .move_count(mc0)
`endif
  );

  nxn_board_game #(.N(5), .K(4)) u_g5 (
    .clk(clk), .rst(rst), .play_x(px[1]), .play_o(po[1]), .x_pos(xp1), .o_pos(op1),
    .board(board5), .turn(turn_w[1]), .busy(busy_w[1]), .illegal(ill_w[1]),
    .who(who1), .game_over(go_w[1])
`ifdef MOVE_COUNT_EN
    , .move_count(mc1)
`endif
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain cell arrays, win found by searching the whole board.
  int mb[2][64];
  int mturn[2];
  int mwho[2];
  int mcount[2];

  function automatic int nn(input int w); return (w != 0) ? 5 : 3; endfunction
  function automatic int kk(input int w); return (w != 0) ? 4 : 3; endfunction

  function automatic logic [49:0] mpack(input int w);
    logic [49:0] v = '0;
    for (int i = 0; i < nn(w)*nn(w); i++) v[2*i +: 2] = 2'(mb[w][i]);
    return v;
  endfunction

  function automatic bit has_line(input int w, input int mark);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    int n = nn(w);
    int k = kk(w);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          bit ok = 1'b1;
          for (int s = 0; s < k; s++) begin
            int rr = r + s*dr[d];
            int cc = c + s*dc[d];
            if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
            else if (mb[w][rr*n+cc] != mark) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic bit mfull(input int w);
    for (int i = 0; i < nn(w)*nn(w); i++) if (mb[w][i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [49:0] dboard(input int w);
    return (w != 0) ? board5 : {32'b0, board3};
  endfunction
  function automatic logic [1:0] dwho(input int w);
    return (w != 0) ? who1 : who0;
  endfunction
  function automatic logic [5:0] dmc(input int w);
`ifdef MOVE_COUNT_EN
    return (w != 0) ? mc1 : {1'b0, mc0};
`else
    return 6'(w);
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input bit x, input bit o, input int pos);
    if (w == 0) begin
      px[0] = x; po[0] = o; xp0 = 4'(pos); op0 = 4'(pos);
    end else begin
      px[1] = x; po[1] = o; xp1 = 5'(pos); op1 = 5'(pos);
    end
  endtask

  task automatic mreset;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 64; i++) mb[w][i] = 0;
      mturn[w] = 0; mwho[w] = 0; mcount[w] = 0;
    end
  endtask

  task automatic check_state(input int w, input string tag);
    check({tag, " board"}, 64'(dboard(w)), 64'(mpack(w)));
    check({tag, " turn"}, 64'(turn_w[w]), 64'(mturn[w]));
    check({tag, " who"}, 64'(dwho(w)), 64'(mwho[w]));
    check({tag, " over"}, 64'(go_w[w]), 64'(mwho[w] != 0));
`ifdef MOVE_COUNT_EN
    check({tag, " mcount"}, 64'(dmc(w)), 64'(mcount[w]));
`endif
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mreset;
    for (int w = 0; w < 2; w++) begin
      check_state(w, $sformatf("rst w%0d", w));
      check($sformatf("rst w%0d busy", w), 64'(busy_w[w]), 64'd0);
      check($sformatf("rst w%0d illegal", w), 64'(ill_w[w]), 64'd0);
    end
  endtask

  // One move request; 'both' raises both strobes with the same position.
  task automatic move(input int w, input bit o, input int pos, input bit both);
    int    n = nn(w);
    int    kind;
    int    mark = (mturn[w] != 0) ? 2 : 1;
    int    free;
    string t = $sformatf("w%0d %s@%0d", w, o ? "O" : "X", pos);
    if (mwho[w] != 0 || (!both && int'(o) != mturn[w])) kind = 0;
    else if (pos >= n*n)                                kind = 1;
    else if (mb[w][pos] != 0)                           kind = 1;
    else                                                kind = 2;
    drive(w, both | ~o, both | o, pos);
    tick;
    drive(w, 0, 0, pos);
    if (kind == 0) begin
      check({t, " ign illegal"}, 64'(ill_w[w]), 64'd0);
      check({t, " ign busy"}, 64'(busy_w[w]), 64'd0);
      check_state(w, {t, " ign"});
    end else if (kind == 1) begin
      check({t, " illegal"}, 64'(ill_w[w]), 64'd1);
      check_state(w, {t, " ill"});
      tick;
      check({t, " illegal drop"}, 64'(ill_w[w]), 64'd0);
    end else begin
      mb[w][pos] = mark;
      mcount[w]++;
      check({t, " busy"}, 64'(busy_w[w]), 64'd1);
      check({t, " placed"}, 64'(dboard(w)), 64'(mpack(w)));
      free = pos;
      for (int i = n*n - 1; i >= 0; i--) if (mb[w][i] == 0) free = i;
      drive(w, 1, 1, free);
      tick;
      tick;
      check({t, " busy ign illegal"}, 64'(ill_w[w]), 64'd0);
      check({t, " busy ign board"}, 64'(dboard(w)), 64'(mpack(w)));
      drive(w, 0, 0, free);
      tick;
      check({t, " who early"}, 64'(dwho(w)), 64'd0);
      tick;
      if (has_line(w, mark)) mwho[w] = mark;
      else if (mfull(w))     mwho[w] = 3;
      else                   mturn[w] = 1 - mturn[w];
      check({t, " busy done"}, 64'(busy_w[w]), 64'd0);
      check_state(w, {t, " done"});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 3x3 row win, then a late O request is ignored.
    do_reset;
    move(0, 0, 0, 0); move(0, 1, 3, 0); move(0, 0, 1, 0); move(0, 1, 4, 0); move(0, 0, 2, 0);
    check("row win who", 64'(who0), 64'd1);
    move(0, 1, 5, 0);

    // Occupied cell rejected, then accepted elsewhere.
    do_reset;
    move(0, 0, 4, 0); move(0, 1, 4, 0);
    check("occupied cell4", 64'(board3[9:8]), 64'd1);
    check("occupied turn", 64'(turn_w[0]), 64'd1);
    move(0, 1, 0, 0);

    // Off-turn strobe ignored; out-of-range position rejected.
    do_reset;
    move(0, 1, 0, 0);
    move(0, 0, 9, 0);
    move(0, 0, 15, 1);

    // Draw.
    do_reset;
    move(0, 0, 0, 0); move(0, 1, 1, 0); move(0, 0, 2, 0); move(0, 1, 4, 0); move(0, 0, 3, 0);
    move(0, 1, 5, 0); move(0, 0, 7, 0); move(0, 1, 6, 0); move(0, 0, 8, 0);
    check("draw who", 64'(who0), 64'd3);
`ifdef MOVE_COUNT_EN
    check("draw move_count", 64'(mc0), 64'd9);
`endif

    // 5x5 K=4 anti-diagonal win.
    do_reset;
    move(1, 0, 3, 0); move(1, 1, 0, 0); move(1, 0, 7, 0); move(1, 1, 1, 0);
    move(1, 0, 11, 0); move(1, 1, 2, 0); move(1, 0, 15, 0);
    check("antidiag who", 64'(who1), 64'd1);

    // No wrap across rows.
    do_reset;
    move(1, 0, 3, 0); move(1, 1, 10, 0); move(1, 0, 4, 0); move(1, 1, 20, 0);
    move(1, 0, 5, 0); move(1, 1, 21, 0); move(1, 0, 6, 0);
    check("wrap who", 64'(who1), 64'd0);

    // Reset during the vertical check aborts the scan.
    do_reset;
    drive(0, 1, 0, 4);
    tick;
    drive(0, 0, 0, 0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mreset;
    check("midrst board", 64'(board3), 64'd0);
    check("midrst busy", 64'(busy_w[0]), 64'd0);
    check("midrst turn", 64'(turn_w[0]), 64'd0);
    check("midrst who", 64'(who0), 64'd0);
    tick;
    check("midrst hold busy", 64'(busy_w[0]), 64'd0);
    check("midrst hold who", 64'(who0), 64'd0);
`ifdef MOVE_COUNT_EN
    check("midrst move_count", 64'(mc0), 64'd0);
`endif

    // Random play on both boards.
    for (int w = 0; w < 2; w++) begin
      for (int g = 0; g < 6; g++) begin
        do_reset;
        for (int m = 0; m < 40 && mwho[w] == 0; m++) begin
          int  r = $urandom_range(0, 9);
          bit  o = (r < 8) ? mturn[w][0] : ~mturn[w][0];
          int  n = nn(w);
          int  pos;
          if ($urandom_range(0, 4) == 0) pos = $urandom_range(0, (w != 0) ? 31 : 15);
          else                           pos = $urandom_range(0, n*n - 1);
          move(w, o, pos, r == 9);
        end
        move(w, mturn[w][0], 0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
